// File: rtl/input_conditioner.sv
// Button/switch conditioner for the CPU ready_in and in_port inputs: synchronise, debounce, snapshot, stretch.
// Optional per-bit switch debouncing is enabled by defining INPUT_COND_SW_DEBOUNCE_EN.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES    = 1000000,
  parameter int HOLD_CYCLES        = 67108864,
  parameter int SW_DEBOUNCE_CYCLES = 1000000
) (
  input  logic       fastclk,
  input  logic       n_reset,
  input  logic       btn_n,
  input  logic [7:0] sw_raw,
  output logic       ready_out,
  output logic [7:0] data_out,
  output logic       busy
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DEB_PRESS = 3'd1;
  localparam logic [2:0] HOLD      = 3'd2;
  localparam logic [2:0] WAIT_REL  = 3'd3;
  localparam logic [2:0] DEB_REL   = 3'd4;

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || SW_DEBOUNCE_CYCLES < 2) begin : g_param_err
    $error("input_conditioner: parameter below its minimum");
  end

  logic             btn_meta_q, btn_s_q;
  logic [7:0]       sw_meta_q, sw_s_q;
  logic [7:0]       sw_cap;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;

  // Button resets to released so a reset never looks like a press edge.
  always_ff @(posedge fastclk or negedge n_reset) begin
    if (!n_reset) begin
      btn_meta_q <= 1'b1;
      btn_s_q    <= 1'b1;
      sw_meta_q  <= 8'h00;
      sw_s_q     <= 8'h00;
    end else begin
      btn_meta_q <= btn_n;
      btn_s_q    <= btn_meta_q;
      sw_meta_q  <= sw_raw;
      sw_s_q     <= sw_meta_q;
    end
  end

`ifdef INPUT_COND_SW_DEBOUNCE_EN
  localparam int SW_W = $clog2(SW_DEBOUNCE_CYCLES);
  localparam logic [SW_W-1:0] SW_LAST = SW_W'(SW_DEBOUNCE_CYCLES - 1);
  localparam logic [SW_W-1:0] SW_ONE  = SW_W'(1);

  logic [7:0]      sw_d_q;
  logic [SW_W-1:0] sw_cnt_q [8];

  always_ff @(posedge fastclk or negedge n_reset) begin
    if (!n_reset) begin
      sw_d_q <= 8'h00;
      for (int i = 0; i < 8; i++) sw_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sw_s_q[i] == sw_d_q[i]) begin
          sw_cnt_q[i] <= '0;
        end else if (sw_cnt_q[i] == SW_LAST) begin
          sw_d_q[i]   <= sw_s_q[i];
          sw_cnt_q[i] <= '0;
        end else begin
          sw_cnt_q[i] <= sw_cnt_q[i] + SW_ONE;
        end
      end
    end
  end

  assign sw_cap = sw_d_q;
`else
  assign sw_cap = sw_s_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (!btn_s_q) begin
          state_d = DEB_PRESS;
          cnt_d   = '0;
        end
      end
      DEB_PRESS: begin
        if (btn_s_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          data_d  = sw_cap;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // Button is deliberately ignored here so the pulse width is fixed.
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
          ready_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WAIT_REL: begin
        if (btn_s_q) begin
          state_d = DEB_REL;
          cnt_d   = '0;
        end
      end
      DEB_REL: begin
        if (!btn_s_q) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge fastclk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign ready_out = ready_q;
  assign data_out  = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: expected ready pulses are queued at press time and matched when the pulse ends.
module tb_input_conditioner;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic       fastclk;
  logic       n_reset;
  logic       btn_n;
  logic [7:0] sw_raw;
  logic       ready_out;
  logic [7:0] data_out;
  logic       busy;

  input_conditioner #(
    .DEBOUNCE_CYCLES   (DEB),
    .HOLD_CYCLES       (HOLD),
    .SW_DEBOUNCE_CYCLES(4)
  ) dut (
    .fastclk  (fastclk),
    .n_reset  (n_reset),
    .btn_n    (btn_n),
    .sw_raw   (sw_raw),
    .ready_out(ready_out),
    .data_out (data_out),
    .busy     (busy)
  );

  typedef struct {
    int         rise;
    int         width;
    logic [7:0] data;
  } pulse_t;

  pulse_t sb_q[$];
  int checks     = 0;
  int failures   = 0;
  int edge_cnt   = 0;
  int rise_edge  = 0;
  int rise_total = 0;
  int pushes     = 0;
  int pops       = 0;
  logic rdy_prev = 1'b0;
  logic mute     = 1'b0;

  initial begin
    fastclk = 1'b0;
    forever #5 fastclk = ~fastclk;
  end

  always @(posedge fastclk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse monitor: a rise records its edge; a fall pops the oldest expectation.
  always @(negedge fastclk) begin
    pulse_t exp_p;
    if (!mute) begin
      if (ready_out && !rdy_prev) begin
        rise_edge = edge_cnt;
        rise_total++;
        if (sb_q.size() == 0) chk("unexpected_pulse_edge", edge_cnt, -1);
      end
      if (!ready_out && rdy_prev && sb_q.size() > 0) begin
        exp_p = sb_q.pop_front();
        pops++;
        chk("pulse_rise_edge", rise_edge, exp_p.rise);
        chk("pulse_width", edge_cnt - rise_edge, exp_p.width);
        chk("pulse_data", int'(data_out), int'(exp_p.data));
      end
    end
    rdy_prev = ready_out;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge fastclk);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge fastclk);
      if (!busy) return;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  // Called at a negedge: the next posedge is the first to sample btn_n low.
  task automatic push_press(input logic [7:0] d);
    pulse_t p;
    p.rise  = edge_cnt + 1 + 2 + DEB;
    p.width = HOLD;
    p.data  = d;
    sb_q.push_back(p);
    pushes++;
  endtask

  task automatic press(input logic [7:0] sw_v, input int hold_n);
    sw_raw = sw_v;
    tick(3);
    btn_n = 1'b0;
    push_press(sw_v);
    tick(hold_n);
    btn_n = 1'b1;
    wait_idle(60);
  endtask

  initial begin
    int e;
    n_reset = 1'b0;
    btn_n   = 1'b1;
    sw_raw  = 8'h00;
    tick(2);
    chk("reset_ready", int'(ready_out), 0);
    chk("reset_data", int'(data_out), 0);
    chk("reset_busy", int'(busy), 0);
    n_reset = 1'b1;
    tick(3);

    // Bounce reject: two short low bursts never complete the debounce.
    btn_n = 1'b0; tick(3);
    btn_n = 1'b1; tick(1);
    btn_n = 1'b0; tick(3);
    btn_n = 1'b1; tick(10);
    chk("bounce_rises", rise_total, 0);
    chk("bounce_data", int'(data_out), 0);
    chk("bounce_busy", int'(busy), 0);

    // Clean press with latency checks on busy.
    sw_raw = 8'hA5;
    tick(3);
    btn_n = 1'b0;
    e = edge_cnt + 1;
    push_press(8'hA5);
    tick(2);
    chk("clean_busy_e2", int'(busy), 0);
    tick(1);
    chk("clean_busy_e3", int'(busy), 1);
    chk("clean_edge_ref", edge_cnt, e + 2);
    tick(3);
    chk("clean_ready_pre", int'(ready_out), 0);
    tick(20);
    chk("clean_data_after", int'(data_out), 'hA5);
    chk("clean_busy_waitrel", int'(busy), 1);
    btn_n = 1'b1;
    wait_idle(60);

    // Held button then a second press.
    press(8'hC3, 100);
    press(8'h96, 20);

    // Snapshot hold: switches move during and after HOLD.
    sw_raw = 8'h3C;
    tick(3);
    btn_n = 1'b0;
    push_press(8'h3C);
    tick(9);
    sw_raw = 8'hFF;
    tick(20);
    chk("snap_data_hold", int'(data_out), 'h3C);
    btn_n = 1'b1;
    wait_idle(60);
    tick(5);
    chk("snap_data_idle", int'(data_out), 'h3C);

    // Reset in the middle of HOLD, button kept low across reset release.
    mute = 1'b1;
    sw_raw = 8'h81;
    tick(3);
    btn_n = 1'b0;
    tick(9);
    chk("pre_reset_ready", int'(ready_out), 1);
    chk("pre_reset_data", int'(data_out), 'h81);
    #1 n_reset = 1'b0;
    #1;
    chk("async_reset_ready", int'(ready_out), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_data", int'(data_out), 0);
    tick(2);
    n_reset = 1'b1;
    mute = 1'b0;
    push_press(8'h81);
    tick(20);
    btn_n = 1'b1;
    wait_idle(60);

`ifdef INPUT_COND_SW_DEBOUNCE_EN
    sw_raw = 8'h00;
    tick(3);
    sw_raw = 8'h01;
    tick(2);
    press(8'h00, 20);
    sw_raw = 8'h01;
    tick(10);
    press(8'h01, 20);
`endif

    tick(20);
    chk("sb_leftover", sb_q.size(), 0);
    chk("pulse_count", pops, pushes);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Conditions the raw board inputs that feed the CPU core: the 8 switches and the active-low "ready" push button. The block runs on the 50 MHz board clock, ahead of the clock divider.
- Synchronises and debounces the button.
- Captures a stable switch snapshot on each press.
- Stretches the press into a ready level long enough for the slow divided CPU clock to sample it at least once.
- Outputs drive the CPU's ready_in and in_port.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive fastclk cycles of stable button level required to accept a press or a release (20 ms at 50 MHz); minimum 2.
HOLD_CYCLES, 67108864, fastclk cycles ready_out stays high per accepted press (2^26, two divided-clock periods at divide-by-2^25); minimum 1.
SW_DEBOUNCE_CYCLES, 1000000, per-bit switch stability requirement; used only when the optional feature is enabled; minimum 2.

Ports:
fastclk  input  1  board clock, 50 MHz; all state on its rising edge
n_reset  input  1  asynchronous active-low reset
btn_n  input  1  raw push button, active-low (0 = pressed), asynchronous to fastclk
sw_raw  input  8  raw slide switches, asynchronous
ready_out  output  1  stretched press indication, connects to CPU ready_in
data_out  output  8  switch snapshot taken at press acceptance, connects to CPU in_port
busy  output  1  high in every state except IDLE

Behaviour:
- Interface (already decided): one clock, fastclk; reset n_reset is asynchronous and active-low.
- Reset values:
  - ready_out=0, data_out=8'h00, busy=0.
  - State IDLE, all counters 0.
  - btn synchroniser flops =1 (released); sw synchroniser flops =0.
- Synchronisers: btn_n and each sw_raw bit pass through a 2-flop synchroniser. All logic uses only the second-stage values (btn_s, sw_s).
- Counter widths: $clog2 of the largest relevant parameter. Counters never wrap; each is cleared on every state entry.
- FSM states and transitions:
  - IDLE: btn_s==0 -> DEB_PRESS, cnt=0.
  - DEB_PRESS:
    - btn_s==1 -> IDLE (bounce rejected).
    - Else if cnt==DEBOUNCE_CYCLES-1 -> HOLD; data_out<=sw_s; ready_out<=1.
    - Else cnt++.
  - HOLD:
    - cnt++ each cycle. btn_s is ignored, so a release or re-press inside HOLD does not shorten or extend it.
    - When cnt==HOLD_CYCLES-1 -> WAIT_REL, ready_out<=0.
  - WAIT_REL: btn_s==1 -> DEB_REL, cnt=0.
  - DEB_REL:
    - btn_s==0 -> WAIT_REL.
    - cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - Else cnt++.
- Latency: with btn_n held low from the first fastclk edge that samples it low (edge 1):
  - IDLE exits at edge 3.
  - ready_out rises at edge 3+DEBOUNCE_CYCLES and stays high for exactly HOLD_CYCLES cycles.
- One press yields exactly one ready_out pulse. A new pulse requires a debounced release followed by a debounced press.
- data_out changes only on the DEB_PRESS->HOLD transition; it is held at all other times, including after ready_out falls.
- busy = (state != IDLE), registered together with the state.
- Reset mid-operation: an immediate return to reset values. Any in-progress ready pulse is truncated.
- Button already held at reset release: a press is accepted normally after debounce.

Optional Feature:
INPUT_COND_SW_DEBOUNCE_EN
- Defined:
  - Each sw bit has its own debouncer: a counter plus a stable value sw_d[i] (reset 0).
  - sw_d[i] updates to sw_s[i] after sw_s[i] differs from sw_d[i] for SW_DEBOUNCE_CYCLES consecutive cycles. Any return to equality clears that bit's counter.
  - data_out captures sw_d instead of sw_s.
- Undefined: no switch debouncing; data_out captures sw_s directly and the SW_DEBOUNCE_CYCLES parameter is unused.

Test Plan:
- Clean press (DEBOUNCE=4, HOLD=8; sw_raw=8'hA5 steady; btn_n 1->0 and held) -> ready_out rises at edge 7, falls at edge 15; data_out=8'hA5 from edge 7 onward; busy high from edge 3.
- Bounce reject (btn_n low 3 cycles, high 1, low 3, high) -> ready_out never rises; state returns to IDLE; data_out stays 8'h00.
- Held button (btn_n low for 100 cycles, then high ≥4 cycles, then low again) -> exactly one pulse during the hold; the second press yields a second 8-cycle pulse.
- Snapshot hold (press with sw=8'h3C; change sw to 8'hFF during HOLD and after) -> data_out remains 8'h3C until the next accepted press.
- Reset mid-HOLD (assert n_reset at HOLD cycle 3) -> ready_out, busy and data_out go to 0 immediately, without a clock edge; after release, a new press behaves per the clean-press timing.
- INPUT_COND_SW_DEBOUNCE_EN with SW_DEBOUNCE=4: toggle sw bit0 for 2 cycles, then press -> data_out bit0 =0. Hold bit0=1 for ≥4 cycles before the press -> bit0 =1.
